// File: rtl/pc_if_hwloop.sv
// Instruction-fetch PC sequencer with registered instruction output, a nested
// hardware-loop stack for zero-overhead repeats, and NOP flush after redirects.
module pc_if_hwloop #(
   parameter int AW          = 10,
   parameter int IW          = 32,
   parameter int CW          = 8,
   parameter int DEPTH       = 4,
   parameter int FLUSH_SLOTS = 2,
   parameter logic [IW-1:0] NOP_PAT = {IW{1'b0}}
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         t_cs,
   input  logic                         lock_rq,
   input  logic                         pc_init_en,
   input  logic [AW-1:0]                pc_init_addr,
   input  logic                         jmp_pc_sel,
   input  logic [AW-1:0]                jmp_addr,
   input  logic                         loop_push,
   input  logic [AW-1:0]                loop_start,
   input  logic [AW-1:0]                loop_end,
   input  logic [CW-1:0]                loop_cnt,
   input  logic [IW-1:0]                ins_mem_i,
   output logic [AW-1:0]                mv_PC,
   output logic                         pc_en_b,
   output logic                         halt,
   output logic [IW-1:0]                mv_ins_reg,
   output logic [$clog2(DEPTH+1)-1:0]   loop_depth,
   output logic                         loop_ovf
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW = (FLUSH_SLOTS > 0) ? $clog2(FLUSH_SLOTS + 1) : 1;
   localparam logic [DW-1:0] FULL_DEPTH = DW'(DEPTH);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_SLOTS);

   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] start_q [DEPTH];
   logic [AW-1:0] start_d [DEPTH];
   logic [AW-1:0] end_q   [DEPTH];
   logic [AW-1:0] end_d   [DEPTH];
   logic [CW-1:0] cnt_q   [DEPTH];
   logic [CW-1:0] cnt_d   [DEPTH];
   logic [DW-1:0] depth_q, depth_d;
   logic          ovf_q, ovf_d;
   logic [FW-1:0] flush_q, flush_d;
   logic          lock_q, lock_d;
   logic [IW-1:0] ins_q, ins_d;

   logic [SW-1:0] topIdx;
   logic [DW-1:0] depthAfter;
   logic          atEnd;

   // Only the top stack entry is ever compared against the PC; popping an
   // inner loop exposes the outer entry for comparison on the following cycle.
   // Pops and decrements settle first so a same-cycle push lands above them.
   always_comb begin
      pc_d       = pc_q;
      start_d    = start_q;
      end_d      = end_q;
      cnt_d      = cnt_q;
      depth_d    = depth_q;
      ovf_d      = ovf_q;
      flush_d    = flush_q;
      lock_d     = lock_q;
      ins_d      = ins_q;
      depthAfter = depth_q;
      topIdx     = SW'(depth_q - DW'(1));
      atEnd      = (depth_q != '0) && (pc_q == end_q[topIdx]);

      if (t_cs) begin
         lock_d = lock_rq;
         ins_d  = (lock_q || (flush_q != '0)) ? NOP_PAT : ins_mem_i;

         if (pc_init_en || jmp_pc_sel) begin
            flush_d = FLUSH_LOAD;
         end else if (flush_q != '0) begin
            flush_d = flush_q - FW'(1);
         end

         if (pc_init_en) begin
            pc_d       = pc_init_addr;
            depthAfter = '0;
         end else if (jmp_pc_sel) begin
            pc_d = jmp_addr;
         end else if (lock_rq) begin
            pc_d = pc_q;
         end else if (atEnd) begin
            if (cnt_q[topIdx] > CW'(1)) begin
               pc_d           = start_q[topIdx];
               cnt_d[topIdx]  = cnt_q[topIdx] - CW'(1);
            end else begin
               pc_d       = pc_q + AW'(1);
               depthAfter = depth_q - DW'(1);
            end
         end else begin
            pc_d = pc_q + AW'(1);
         end

         depth_d = depthAfter;

         if (loop_push) begin
            if (depthAfter == FULL_DEPTH) begin
               ovf_d = 1'b1;
            end else begin
               start_d[SW'(depthAfter)] = loop_start;
               end_d[SW'(depthAfter)]   = loop_end;
               cnt_d[SW'(depthAfter)]   = (loop_cnt == '0) ? CW'(1) : loop_cnt;
               depth_d                  = depthAfter + DW'(1);
            end
         end
      end
   end

   // Holding every register when t_cs is low falls out of the defaults above.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         flush_q <= '0;
         lock_q  <= 1'b0;
         ins_q   <= NOP_PAT;
         for (int i = 0; i < DEPTH; i++) begin
            start_q[i] <= '0;
            end_q[i]   <= '0;
            cnt_q[i]   <= '0;
         end
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         flush_q <= flush_d;
         lock_q  <= lock_d;
         ins_q   <= ins_d;
         start_q <= start_d;
         end_q   <= end_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mv_PC      = pc_q;
   assign pc_en_b    = 1'b0;
   assign halt       = (ins_mem_i == NOP_PAT);
   assign mv_ins_reg = ins_q;
   assign loop_depth = depth_q;
   assign loop_ovf   = ovf_q;

endmodule

// File: tb/tb_pc_if_hwloop.sv
// Directed bench for pc_if_hwloop: a 1-cycle synchronous instruction memory
// model feeds the DUT, and each step checks PC, stack and instruction output.
module tb_pc_if_hwloop;

   logic        clk = 1'b0;
   logic        reset;
   logic        tCs;
   logic        lockRq;
   logic        pcInitEn;
   logic [9:0]  pcInitAddr;
   logic        jmpPcSel;
   logic [9:0]  jmpAddr;
   logic        loopPush;
   logic [9:0]  loopStart;
   logic [9:0]  loopEnd;
   logic [7:0]  loopCnt;
   logic [31:0] insMem;
   logic [9:0]  mvPc;
   logic        pcEnB;
   logic        halt;
   logic [31:0] mvInsReg;
   logic [2:0]  loopDepth;
   logic        loopOvf;

   int nAssert = 0;
   int nFail   = 0;

   localparam logic [9:0] SEQ2 [10] = '{10'h011, 10'h012, 10'h013, 10'h011, 10'h012,
                                        10'h013, 10'h011, 10'h012, 10'h013, 10'h014};
   localparam logic [9:0] SEQ3 [16] = '{10'h021, 10'h022, 10'h021, 10'h022, 10'h023, 10'h024,
                                        10'h025, 10'h020, 10'h021, 10'h022, 10'h021, 10'h022,
                                        10'h023, 10'h024, 10'h025, 10'h026};
   localparam logic [2:0] DEP3 [16] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1,
                                        3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0};

   pc_if_hwloop dut (
      .clk          (clk),
      .reset        (reset),
      .t_cs         (tCs),
      .lock_rq      (lockRq),
      .pc_init_en   (pcInitEn),
      .pc_init_addr (pcInitAddr),
      .jmp_pc_sel   (jmpPcSel),
      .jmp_addr     (jmpAddr),
      .loop_push    (loopPush),
      .loop_start   (loopStart),
      .loop_end     (loopEnd),
      .loop_cnt     (loopCnt),
      .ins_mem_i    (insMem),
      .mv_PC        (mvPc),
      .pc_en_b      (pcEnB),
      .halt         (halt),
      .mv_ins_reg   (mvInsReg),
      .loop_depth   (loopDepth),
      .loop_ovf     (loopOvf)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [9:0] a);
      return 32'hC0DE_0000 | {22'd0, a};
   endfunction

   // Instruction memory model: one-cycle read latency, paused while the core is deselected.
   always @(posedge clk) begin
      if (reset) insMem <= 32'h0;
      else if (tCs) insMem <= memWord(mvPc);
   end

   task automatic applyStimulus();
      @(posedge clk);
      #1;
      pcInitEn = 1'b0;
      jmpPcSel = 1'b0;
      loopPush = 1'b0;
      lockRq   = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic setPush(input logic [9:0] s, input logic [9:0] e, input logic [7:0] c);
      loopPush  = 1'b1;
      loopStart = s;
      loopEnd   = e;
      loopCnt   = c;
   endtask

   initial begin
      reset = 1'b1; tCs = 1'b1; lockRq = 1'b0; pcInitEn = 1'b0; pcInitAddr = '0;
      jmpPcSel = 1'b0; jmpAddr = '0; loopPush = 1'b0; loopStart = '0; loopEnd = '0; loopCnt = '0;
      applyStimulus();
      applyStimulus();
      checkOutput("reset_pc", 32'(mvPc), 32'h0);
      checkOutput("reset_ins", mvInsReg, 32'h0);
      checkOutput("reset_depth", 32'(loopDepth), 32'd0);
      checkOutput("reset_ovf", 32'(loopOvf), 32'd0);
      checkOutput("pc_en_b", 32'(pcEnB), 32'd0);
      checkOutput("halt_on_nop", 32'(halt), 32'd1);
      reset = 1'b0;

      // Single loop, three iterations.
      pcInitEn = 1'b1; pcInitAddr = 10'h010; setPush(10'h011, 10'h013, 8'd3);
      applyStimulus();
      checkOutput("t2_init_pc", 32'(mvPc), 32'h010);
      checkOutput("t2_init_depth", 32'(loopDepth), 32'd1);
      checkOutput("halt_on_ins", 32'(halt), 32'd0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus();
         checkOutput($sformatf("t2_pc_%0d", i), 32'(mvPc), 32'(SEQ2[i]));
         checkOutput($sformatf("t2_depth_%0d", i), 32'(loopDepth), (i == 9) ? 32'd0 : 32'd1);
      end
      checkOutput("t2_ins_after", mvInsReg, memWord(10'h012));

      // Nested loops; software re-pushes the inner loop each outer pass.
      pcInitEn = 1'b1; pcInitAddr = 10'h020; setPush(10'h020, 10'h025, 8'd2);
      applyStimulus();
      checkOutput("t3_init_depth", 32'(loopDepth), 32'd1);
      for (int i = 0; i < 16; i++) begin
         if (i == 0 || i == 8) setPush(10'h021, 10'h022, 8'd2);
         applyStimulus();
         checkOutput($sformatf("t3_pc_%0d", i), 32'(mvPc), 32'(SEQ3[i]));
         checkOutput($sformatf("t3_depth_%0d", i), 32'(loopDepth), 32'(DEP3[i]));
      end

      // Jump with two flush slots; the word fetched at 0x40 falls in the second slot.
      jmpPcSel = 1'b1; jmpAddr = 10'h040;
      applyStimulus();
      checkOutput("t4_jmp_pc", 32'(mvPc), 32'h040);
      checkOutput("t4_pre_ins", mvInsReg, memWord(10'h025));
      applyStimulus();
      checkOutput("t4_nop1", mvInsReg, 32'h0);
      applyStimulus();
      checkOutput("t4_nop2", mvInsReg, 32'h0);
      applyStimulus();
      checkOutput("t4_resume_ins", mvInsReg, memWord(10'h041));
      checkOutput("t4_pc", 32'(mvPc), 32'h043);

      // Fill the stack, overflow it, then stall at a loop end.
      pcInitEn = 1'b1; pcInitAddr = 10'h050; setPush(10'h060, 10'h06F, 8'd5);
      applyStimulus();
      setPush(10'h300, 10'h310, 8'd1);
      applyStimulus();
      setPush(10'h320, 10'h330, 8'd1);
      applyStimulus();
      setPush(10'h054, 10'h055, 8'd2);
      applyStimulus();
      checkOutput("t5_full_depth", 32'(loopDepth), 32'd4);
      checkOutput("t5_no_ovf_yet", 32'(loopOvf), 32'd0);
      setPush(10'h001, 10'h002, 8'd1);
      applyStimulus();
      checkOutput("t5_pc", 32'(mvPc), 32'h054);
      checkOutput("t5_depth_held", 32'(loopDepth), 32'd4);
      checkOutput("t5_ovf", 32'(loopOvf), 32'd1);
      applyStimulus();
      checkOutput("t5_at_end", 32'(mvPc), 32'h055);
      lockRq = 1'b1;
      applyStimulus();
      checkOutput("t5_lock_pc", 32'(mvPc), 32'h055);
      checkOutput("t5_lock_ins", mvInsReg, memWord(10'h054));
      applyStimulus();
      checkOutput("t5_loopback", 32'(mvPc), 32'h054);
      checkOutput("t5_lock_nop", mvInsReg, 32'h0);
      checkOutput("t5_depth", 32'(loopDepth), 32'd4);
      applyStimulus();
      checkOutput("t5_ins_after_nop", mvInsReg, memWord(10'h055));
      applyStimulus();
      checkOutput("t5_pop_pc", 32'(mvPc), 32'h056);
      checkOutput("t5_pop_depth", 32'(loopDepth), 32'd3);

      // Freeze during a pending flush, then run through the address wrap.
      pcInitEn = 1'b1; pcInitAddr = 10'h3FD; setPush(10'h3FE, 10'h3FF, 8'd2);
      applyStimulus();
      checkOutput("t6_init_pc", 32'(mvPc), 32'h3FD);
      checkOutput("t6_init_depth", 32'(loopDepth), 32'd1);
      checkOutput("t6_ovf_sticky", 32'(loopOvf), 32'd1);
      tCs = 1'b0;
      for (int i = 0; i < 3; i++) begin
         lockRq = 1'b1; setPush(10'h100, 10'h101, 8'd1);
         applyStimulus();
         checkOutput($sformatf("t6_frz_pc_%0d", i), 32'(mvPc), 32'h3FD);
         checkOutput($sformatf("t6_frz_depth_%0d", i), 32'(loopDepth), 32'd1);
         checkOutput($sformatf("t6_frz_ins_%0d", i), mvInsReg, memWord(10'h055));
      end
      tCs = 1'b1;
      applyStimulus();
      checkOutput("t6_pc_a", 32'(mvPc), 32'h3FE);
      checkOutput("t6_nop1", mvInsReg, 32'h0);
      applyStimulus();
      checkOutput("t6_pc_b", 32'(mvPc), 32'h3FF);
      checkOutput("t6_nop2", mvInsReg, 32'h0);
      applyStimulus();
      checkOutput("t6_pc_c", 32'(mvPc), 32'h3FE);
      checkOutput("t6_ins_c", mvInsReg, memWord(10'h3FE));
      applyStimulus();
      checkOutput("t6_pc_d", 32'(mvPc), 32'h3FF);
      setPush(10'h001, 10'h002, 8'd1);
      applyStimulus();
      checkOutput("t6_wrap_pc", 32'(mvPc), 32'h000);
      checkOutput("t6_poppush_depth", 32'(loopDepth), 32'd1);
      checkOutput("t6_wrap_ins", mvInsReg, memWord(10'h3FE));
      applyStimulus();
      applyStimulus();
      checkOutput("t6_pc_e", 32'(mvPc), 32'h002);
      applyStimulus();
      checkOutput("t6_pc_f", 32'(mvPc), 32'h003);
      checkOutput("t6_depth_f", 32'(loopDepth), 32'd0);

      // A zero iteration count runs the body once.
      pcInitEn = 1'b1; pcInitAddr = 10'h080; setPush(10'h081, 10'h081, 8'd0);
      applyStimulus();
      applyStimulus();
      checkOutput("cnt0_pc_a", 32'(mvPc), 32'h081);
      applyStimulus();
      checkOutput("cnt0_pc_b", 32'(mvPc), 32'h082);
      checkOutput("cnt0_depth", 32'(loopDepth), 32'd0);

      // Reset in the middle of a two-deep nest.
      pcInitEn = 1'b1; pcInitAddr = 10'h090; setPush(10'h091, 10'h095, 8'd3);
      applyStimulus();
      setPush(10'h092, 10'h093, 8'd2);
      applyStimulus();
      checkOutput("t1_depth_before", 32'(loopDepth), 32'd2);
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      checkOutput("t1_pc", 32'(mvPc), 32'h0);
      checkOutput("t1_depth", 32'(loopDepth), 32'd0);
      checkOutput("t1_ins", mvInsReg, 32'h0);
      checkOutput("t1_ovf", 32'(loopOvf), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
